// File: rtl/quat_sync_sink_if.sv
// quat_sync_sink_if: the two handshake links of the quaternary sink.
//
// NCL side (4-phase, return to zero):
//   quat_in  : 1-of-4 rails, all-zero = NULL wavefront
//   quat_ack : completion, 1 = DATA consumed / request NULL, 0 = request DATA
// Clocked side:
//   out_valid, out_ready, out_data
//
// Valid/ready semantics: a transfer happens on a rising clk edge where
// out_valid and out_ready are both 1. While out_valid is 1, out_data is
// stable and out_valid stays high until that transfer. out_ready may change
// freely and never depends combinationally on out_valid.
//
// master: the adder output link plus the clocked consumer (drives rails and ready)
// slave : the sink itself
interface quat_sync_sink_if;
    logic [3:0] quat_in;
    logic       quat_ack;
    logic       out_valid;
    logic       out_ready;
    logic [1:0] out_data;

    modport master (output quat_in, output out_ready,
                    input  quat_ack, input out_valid, input out_data);
    modport slave  (input  quat_in, input out_ready,
                    output quat_ack, output out_valid, output out_data);
endinterface

// File: rtl/quat_sync_sink.sv
// quat_sync_sink: clocked receiver for a 1-of-4 NCL quaternary link.
// Synchronises the rails, acknowledges each DATA/NULL wavefront, decodes
// DATA to a 2-bit value into a small FIFO, keeps a running sum and counts
// illegal (multi-rail) codes.
//
// Ports:
//   clk        : rising-edge clock
//   init_n     : asynchronous active-low reset
//   link       : quat_sync_sink_if.slave (rails/ack, out_valid/ready/data)
//   fifo_level : FIFO occupancy, 0..FIFO_DEPTH
//   sum        : running sum of accepted values, wraps
//   err        : sticky illegal-code flag
//   err_count  : saturating illegal-code count
//   err_clr    : synchronous clear of err/err_count (a same-edge illegal code wins)
//   state_dbg  : FSM state, 0 = WAIT_DATA, 1 = WAIT_NULL
module quat_sync_sink #(
    parameter int FIFO_DEPTH  = 4,
    parameter int SYNC_STAGES = 2,
    parameter int SUM_WIDTH   = 16,
    parameter int ERR_WIDTH   = 8
) (
    input  logic                        clk,
    input  logic                        init_n,
    quat_sync_sink_if.slave             link,
    output logic [$clog2(FIFO_DEPTH):0] fifo_level,
    output logic [SUM_WIDTH-1:0]        sum,
    output logic                        err,
    output logic [ERR_WIDTH-1:0]        err_count,
    input  logic                        err_clr,
    output logic                        state_dbg
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int LW = AW + 1;

    typedef enum logic {WAIT_DATA = 1'b0, WAIT_NULL = 1'b1} state_t;

    state_t state, state_nx;

    // Rail synchroniser. The chain holds SYNC_STAGES-1 flops; the state,
    // FIFO and sum registers that sample q are the final stage, so a rail
    // rising before edge k is acted on at edge k+SYNC_STAGES-1.
    logic [3:0] sync_q [SYNC_STAGES-1];
    logic [3:0] q;

    always_ff @(posedge clk or negedge init_n) begin
        if (!init_n) begin
            for (int i = 0; i < SYNC_STAGES-1; i++) sync_q[i] <= '0;
        end else begin
            sync_q[0] <= link.quat_in;
            for (int i = 1; i < SYNC_STAGES-1; i++) sync_q[i] <= sync_q[i-1];
        end
    end

    assign q = sync_q[SYNC_STAGES-2];

    // Code classification
    logic       q_onehot, q_multi;
    logic [1:0] q_idx;

    always_comb begin
        q_onehot = (q != 4'd0) && ((q & (q - 4'd1)) == 4'd0);
        q_multi  = (q != 4'd0) && !q_onehot;
        case (q)
            4'b0010: q_idx = 2'd1;
            4'b0100: q_idx = 2'd2;
            4'b1000: q_idx = 2'd3;
            default: q_idx = 2'd0;
        endcase
    end

    // FIFO state
    logic [1:0]    mem [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr, rd_ptr_nx;
    logic [LW-1:0] level, level_nx;
    logic          out_valid_q;
    logic [1:0]    out_data_q, head_nx;
    logic          pop, push_ok, push, err_hit;

    assign pop     = out_valid_q & link.out_ready;
    assign push_ok = (level != LW'(FIFO_DEPTH)) || pop;

    // FSM: state register
    always_ff @(posedge clk or negedge init_n) begin
        if (!init_n) state <= WAIT_DATA;
        else         state <= state_nx;
    end

    // FSM: next state. A full FIFO keeps us in WAIT_DATA with ack low,
    // which stalls the NCL pipeline until a slot frees.
    always_comb begin
        state_nx = state;
        case (state)
            WAIT_DATA: if (q_multi || (q_onehot && push_ok)) state_nx = WAIT_NULL;
            WAIT_NULL: if (q == 4'd0)                        state_nx = WAIT_DATA;
        endcase
    end

    // FSM: outputs. quat_ack is the 1-bit state flop itself, so it cannot glitch.
    always_comb begin
        push          = (state == WAIT_DATA) && q_onehot && push_ok;
        err_hit       = (state == WAIT_DATA) && q_multi;
        link.quat_ack = (state == WAIT_NULL);
        state_dbg     = state;
    end

    // FIFO next-state. The registered head must reflect the entry being
    // written this edge when it becomes the head (push into empty FIFO).
    always_comb begin
        rd_ptr_nx = pop ? rd_ptr + AW'(1) : rd_ptr;
        level_nx  = level;
        case ({push, pop})
            2'b10:   level_nx = level + LW'(1);
            2'b01:   level_nx = level - LW'(1);
            default: level_nx = level;
        endcase
        head_nx = (push && (rd_ptr_nx == wr_ptr)) ? q_idx : mem[rd_ptr_nx];
    end

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= q_idx;
    end

    always_ff @(posedge clk or negedge init_n) begin
        if (!init_n) begin
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            level       <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= 2'd0;
        end else begin
            if (push) wr_ptr <= wr_ptr + AW'(1);
            rd_ptr      <= rd_ptr_nx;
            level       <= level_nx;
            out_valid_q <= (level_nx != '0);
            if (level_nx != '0) out_data_q <= head_nx;
        end
    end

    // Running sum and illegal-code tracking
    always_ff @(posedge clk or negedge init_n) begin
        if (!init_n) begin
            sum       <= '0;
            err       <= 1'b0;
            err_count <= '0;
        end else begin
            if (push) sum <= sum + SUM_WIDTH'(q_idx);
            if (err_hit) begin
                err <= 1'b1;
                if (err_clr)               err_count <= ERR_WIDTH'(1);
                else if (err_count != '1)  err_count <= err_count + ERR_WIDTH'(1);
            end else if (err_clr) begin
                err       <= 1'b0;
                err_count <= '0;
            end
        end
    end

    assign link.out_valid = out_valid_q;
    assign link.out_data  = out_data_q;
    assign fifo_level     = level;

endmodule

// File: tb/tb_quat_sync_sink.sv
// tb_quat_sync_sink: self-checking bench for quat_sync_sink.
// A default-parameter instance carries the handshake; a second instance with
// SUM_WIDTH=4 / ERR_WIDTH=2 sees the same rails and ready so that sum wrap
// and err_count saturation can be observed on the same traffic.
module tb_quat_sync_sink;
    localparam int LW = 3;

    // Clock / reset
    logic clk = 1'b0;
    logic init_n = 1'b0;
    logic err_clr = 1'b0;
    always #5 clk = ~clk;

    quat_sync_sink_if lnk ();
    quat_sync_sink_if nar ();
    assign nar.quat_in   = lnk.quat_in;
    assign nar.out_ready = lnk.out_ready;

    logic [LW-1:0] fifo_level, n_level;
    logic [15:0]   sum;
    logic [3:0]    n_sum;
    logic          err, n_err, st, n_st;
    logic [7:0]    err_count;
    logic [1:0]    n_err_count;

    quat_sync_sink dut (
        .clk(clk), .init_n(init_n), .link(lnk), .fifo_level(fifo_level),
        .sum(sum), .err(err), .err_count(err_count), .err_clr(err_clr),
        .state_dbg(st)
    );

    quat_sync_sink #(.SUM_WIDTH(4), .ERR_WIDTH(2)) dut_nar (
        .clk(clk), .init_n(init_n), .link(nar), .fifo_level(n_level),
        .sum(n_sum), .err(n_err), .err_count(n_err_count), .err_clr(err_clr),
        .state_dbg(n_st)
    );

    // Scoreboard state
    logic [1:0] exp_q[$];
    int         exp_sum = 0;
    int         n_checks = 0;
    int         n_errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Output monitor: a transfer is committed at the next rising edge, so the
    // head is compared on the falling edge before it.
    always @(negedge clk) begin
        if (init_n && lnk.out_valid && lnk.out_ready) begin
            check("out_expected", 32'(exp_q.size() != 0), 32'd1);
            if (exp_q.size() != 0) check("out_data", 32'(lnk.out_data), 32'(exp_q.pop_front()));
        end
    end

    // Driver tasks
    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic wait_ack(input logic v, input string tag);
        int n = 0;
        while (lnk.quat_ack !== v && n < 40) begin
            tick();
            n++;
        end
        check(tag, 32'(lnk.quat_ack), 32'(v));
    endtask

    // Full 4-phase transaction; one-hot codes are expected to be captured.
    task automatic send(input logic [3:0] rails);
        lnk.quat_in = rails;
        if ($countones(rails) == 1) begin
            for (int i = 0; i < 4; i++) begin
                if (rails[i]) begin
                    exp_q.push_back(2'(i));
                    exp_sum += i;
                end
            end
        end
        wait_ack(1'b1, "ack_rise");
        lnk.quat_in = 4'd0;
        wait_ack(1'b0, "ack_fall");
    endtask

    task automatic drain();
        int n = 0;
        lnk.out_ready = 1'b1;
        while (exp_q.size() != 0 && n < 50) begin
            tick();
            n++;
        end
        tick();
        check("drain_empty", 32'(exp_q.size()), 32'd0);
        check("drain_level", 32'(fifo_level), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    initial begin
        int v;
        lnk.quat_in   = 4'd0;
        lnk.out_ready = 1'b0;
        repeat (3) @(posedge clk);
        #2;
        check("rst_ack",       32'(lnk.quat_ack),  32'd0);
        check("rst_valid",     32'(lnk.out_valid), 32'd0);
        check("rst_data",      32'(lnk.out_data),  32'd0);
        check("rst_level",     32'(fifo_level),    32'd0);
        check("rst_sum",       32'(sum),           32'd0);
        check("rst_err",       32'(err),           32'd0);
        check("rst_err_count", 32'(err_count),     32'd0);
        check("rst_state",     32'(st),            32'd0);
        init_n = 1'b1;
        tick();

        // Single value 2 with exact latency on both phases
        lnk.quat_in = 4'b0100;
        exp_q.push_back(2'd2);
        exp_sum += 2;
        tick();
        check("lat_rise_early", 32'(lnk.quat_ack), 32'd0);
        tick();
        check("lat_rise",       32'(lnk.quat_ack), 32'd1);
        lnk.quat_in = 4'd0;
        tick();
        check("lat_fall_early", 32'(lnk.quat_ack), 32'd1);
        tick();
        check("lat_fall",       32'(lnk.quat_ack), 32'd0);
        check("t1_data",  32'(lnk.out_data),  32'd2);
        check("t1_valid", 32'(lnk.out_valid), 32'd1);
        check("t1_sum",   32'(sum),           32'd2);
        check("t1_level", 32'(fifo_level),    32'd1);

        // Streaming sequence with the consumer always ready
        lnk.out_ready = 1'b1;
        send(4'b0001); send(4'b0010); send(4'b0100);
        send(4'b1000); send(4'b1000); send(4'b0100);
        drain();
        check("t2_sum", 32'(sum), 32'(exp_sum % 65536));
        check("t2_err", 32'(err), 32'd0);

        // Backpressure: fill, stall the 5th, release with a one-cycle ready pulse
        lnk.out_ready = 1'b0;
        tick();
        for (int i = 0; i < 4; i++) send(4'(1 << $urandom_range(0, 3)));
        check("bp_full", 32'(fifo_level), 32'd4);
        v = $urandom_range(0, 3);
        lnk.quat_in = 4'(1 << v);
        exp_q.push_back(2'(v));
        exp_sum += v;
        repeat (6) tick();
        check("bp_stall_ack",   32'(lnk.quat_ack), 32'd0);
        check("bp_stall_level", 32'(fifo_level),   32'd4);
        lnk.out_ready = 1'b1;
        tick();
        lnk.out_ready = 1'b0;
        check("bp_push_pop_level", 32'(fifo_level),   32'd4);
        check("bp_ack",            32'(lnk.quat_ack), 32'd1);
        lnk.quat_in = 4'd0;
        wait_ack(1'b0, "bp_ack_fall");
        drain();
        check("bp_sum", 32'(sum), 32'(exp_sum % 65536));

        // Illegal codes and err_clr priority
        lnk.out_ready = 1'b0;
        tick();
        lnk.quat_in = 4'b0110;
        wait_ack(1'b1, "ill_ack");
        check("ill_err",       32'(err),           32'd1);
        check("ill_err_count", 32'(err_count),     32'd1);
        check("ill_no_push",   32'(fifo_level),    32'd0);
        check("ill_no_valid",  32'(lnk.out_valid), 32'd0);
        check("ill_sum",       32'(sum),           32'(exp_sum % 65536));
        lnk.quat_in = 4'd0;
        wait_ack(1'b0, "ill_ack_fall");
        send(4'b0001);
        check("ill_then_push", 32'(fifo_level), 32'd1);
        err_clr = 1'b1;
        lnk.quat_in = 4'b1010;
        wait_ack(1'b1, "clr_ack");
        err_clr = 1'b0;
        check("clr_err",       32'(err),       32'd1);
        check("clr_err_count", 32'(err_count), 32'd1);
        lnk.quat_in = 4'd0;
        wait_ack(1'b0, "clr_ack_fall");
        send(4'b1100); send(4'b1111); send(4'b0111);
        check("err_count4",     32'(err_count),   32'd4);
        check("nar_err_sat",    32'(n_err_count), 32'd3);
        check("ill_level",      32'(fifo_level),  32'd1);
        err_clr = 1'b1;
        tick();
        err_clr = 1'b0;
        check("clr_only_err",   32'(err),       32'd0);
        check("clr_only_count", 32'(err_count), 32'd0);
        drain();

        // Sum wrap on the narrow instance
        for (int i = 0; i < 6; i++) send(4'b1000);
        drain();
        check("wrap_wide_sum", 32'(sum),   32'(exp_sum % 65536));
        check("wrap_nar_sum",  32'(n_sum), 32'(exp_sum % 16));

        // Asynchronous reset mid-wavefront with two entries held
        lnk.out_ready = 1'b0;
        tick();
        send(4'(1 << $urandom_range(0, 3)));
        lnk.quat_in = 4'b0100;
        wait_ack(1'b1, "pre_rst_ack");
        check("pre_rst_level", 32'(fifo_level), 32'd2);
        init_n = 1'b0;
        #1;
        check("arst_ack",   32'(lnk.quat_ack),  32'd0);
        check("arst_valid", 32'(lnk.out_valid), 32'd0);
        check("arst_data",  32'(lnk.out_data),  32'd0);
        check("arst_level", 32'(fifo_level),    32'd0);
        check("arst_sum",   32'(sum),           32'd0);
        exp_q.delete();
        exp_sum = 0;
        lnk.quat_in = 4'd0;
        tick();
        init_n = 1'b1;
        tick();
        send(4'b0010);
        check("post_rst_level", 32'(fifo_level), 32'd1);
        drain();
        check("post_rst_sum", 32'(sum), 32'd1);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end
endmodule
